// File: rtl/quad_encoder_emulator_if.sv
// rtl/quad_encoder_emulator_if.sv - control inputs and encoder outputs of quad_encoder_emulator
interface quad_encoder_emulator_if #(
    parameter int EDGE_PERIOD_W = 24,
    parameter int BURST_W       = 16,
    parameter int POS_W         = 32
);
    logic                     Start;
    logic                     Stop;
    logic                     Reverse;
    logic [EDGE_PERIOD_W-1:0] EdgePeriod;
    logic [BURST_W-1:0]       BurstEdges;
    logic                     PosClear;
    logic                     A;
    logic                     B;
    logic                     Z;
    logic                     Busy;
    logic                     Done;
    logic [POS_W-1:0]         Position;

    modport master (
        output Start, Stop, Reverse, EdgePeriod, BurstEdges, PosClear,
        input  A, B, Z, Busy, Done, Position
    );

    modport slave (
        input  Start, Stop, Reverse, EdgePeriod, BurstEdges, PosClear,
        output A, B, Z, Busy, Done, Position
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// rtl/quad_encoder_emulator.sv - quadrature A/B wheel-encoder waveform generator with burst and position tracking
// Index pulse Z and its revolution counter are built only when QENC_INDEX_EN is defined.
module quad_encoder_emulator #(
    parameter int EDGE_PERIOD_W = 24,
    parameter int BURST_W       = 16,
    parameter int POS_W         = 32,
    parameter int EDGES_PER_REV = 80
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    quad_encoder_emulator_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [EDGE_PERIOD_W-1:0] timer;
    logic [EDGE_PERIOD_W-1:0] eff_period;
    logic [BURST_W-1:0]       remaining;
    logic                     burst_mode;
    logic [1:0]               step_idx;
    logic [1:0]               step_next;
    logic                     a_q;
    logic                     b_q;
    logic                     busy_q;
    logic                     done_q;
    logic [POS_W-1:0]         pos_q;
    logic                     step;
    logic                     finish;

    // step_idx counts 0..3 through the quadrature cycle; A = ^idx and B = idx[1] give AB 00,10,11,01.
    always_comb begin
        eff_period = (bus.EdgePeriod < EDGE_PERIOD_W'(2)) ? EDGE_PERIOD_W'(2) : bus.EdgePeriod;
        step       = (state == RUN) && !bus.Stop && (timer == EDGE_PERIOD_W'(1));
        finish     = (state == RUN) && !bus.Stop && burst_mode && (remaining == '0);
        step_next  = bus.Reverse ? (step_idx - 2'd1) : (step_idx + 2'd1);
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            timer      <= '0;
            remaining  <= '0;
            burst_mode <= 1'b0;
            step_idx   <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pos_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start && !bus.Stop) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        remaining  <= bus.BurstEdges;
                        burst_mode <= (bus.BurstEdges != '0);
                        timer      <= eff_period;
                    end
                end
                RUN: begin
                    if (bus.Stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        timer  <= '0;
                    end else if (finish) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (step) begin
                        step_idx <= step_next;
                        a_q      <= ^step_next;
                        b_q      <= step_next[1];
                        timer    <= eff_period;
                        if (burst_mode) begin
                            remaining <= remaining - BURST_W'(1);
                        end
                    end else begin
                        timer <= timer - EDGE_PERIOD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.PosClear) begin
                pos_q <= '0;
            end else if (step) begin
                pos_q <= bus.Reverse ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
            end
        end
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Position = pos_q;

`ifdef QENC_INDEX_EN
    localparam int REV_W = (EDGES_PER_REV > 1) ? $clog2(EDGES_PER_REV) : 1;
    localparam logic [REV_W-1:0] REV_LAST = REV_W'(EDGES_PER_REV - 1);

    logic [REV_W-1:0] rev_cnt;
    logic [REV_W-1:0] rev_next;
    logic             z_q;

    always_comb begin
        if (bus.PosClear) begin
            rev_next = '0;
        end else if (bus.Reverse) begin
            rev_next = (rev_cnt == '0) ? REV_LAST : (rev_cnt - REV_W'(1));
        end else begin
            rev_next = (rev_cnt == REV_LAST) ? '0 : (rev_cnt + REV_W'(1));
        end
    end

    // Z marks the single quadrature state AB=00 at revolution count 0, re-evaluated whenever either moves.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            rev_cnt <= '0;
            z_q     <= 1'b0;
        end else if (step) begin
            rev_cnt <= rev_next;
            z_q     <= (step_next == 2'd0) && (rev_next == '0);
        end else if (bus.PosClear) begin
            rev_cnt <= '0;
            z_q     <= (step_idx == 2'd0);
        end
    end

    assign bus.Z = z_q;
`else
    assign bus.Z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// tb/tb_quad_encoder_emulator.sv - scoreboard bench for quad_encoder_emulator
module tb_quad_encoder_emulator;
    localparam int REV = 8;
`ifdef QENC_INDEX_EN
    localparam bit INDEX_EN = 1'b1;
`else
    localparam bit INDEX_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [1:0]  ab;
        logic [31:0] pos;
        logic        z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    logic [1:0] prev_ab;
    logic [1:0] cur_ab;
    exp_t e;
    exp_t edge_q[$];
    int   done_q[$];
    int   m_idx;
    logic [31:0] m_pos;
    int   m_rev;
    int   s;
    int   dc;

    quad_encoder_emulator_if #(.POS_W(32)) q ();
    quad_encoder_emulator_if #(.POS_W(4))  w ();

    quad_encoder_emulator #(.EDGES_PER_REV(REV)) u_dut (
        .CLOCK_50(clk),
        .Reset   (rst_n),
        .bus     (q)
    );

    quad_encoder_emulator #(.POS_W(4), .EDGES_PER_REV(REV)) u_wrap (
        .CLOCK_50(clk),
        .Reset   (rst_n),
        .bus     (w)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] ab_of(input int idx);
        case (idx)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic push_edge(input int at, input bit rev, input bit clr);
        exp_t x;
        m_idx = rev ? (m_idx + 3) % 4 : (m_idx + 1) % 4;
        if (clr) begin
            m_pos = 32'd0;
            m_rev = 0;
        end else begin
            m_pos = rev ? m_pos - 32'd1 : m_pos + 32'd1;
            m_rev = rev ? (m_rev + REV - 1) % REV : (m_rev + 1) % REV;
        end
        x.cyc = at;
        x.ab  = ab_of(m_idx);
        x.pos = m_pos;
        x.z   = INDEX_EN && (m_idx == 0) && (m_rev == 0);
        edge_q.push_back(x);
    endtask

    // Edge and Done monitor: every observed A/B change and Done pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur_ab = {q.A, q.B};
                if (cur_ab !== prev_ab) begin
                    check_val("ab_single_change", ((cur_ab ^ prev_ab) == 2'b11), 0);
                    if (edge_q.size() == 0) begin
                        check_val("spurious_edge", 1, 0);
                    end else begin
                        e = edge_q.pop_front();
                        check_val("edge_cycle", cyc, e.cyc);
                        check_val("edge_ab", cur_ab, e.ab);
                        check_val("edge_pos", q.Position, e.pos);
                        check_val("edge_z", q.Z, e.z);
                    end
                    prev_ab = cur_ab;
                end
                if (q.Done === 1'b1) begin
                    check_val("done_busy_low", q.Busy, 0);
                    if (done_q.size() == 0) begin
                        check_val("spurious_done", 1, 0);
                    end else begin
                        dc = done_q.pop_front();
                        check_val("done_cycle", cyc, dc);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        edge_q.delete();
        done_q.delete();
        m_idx = 0;
        m_pos = 32'd0;
        m_rev = 0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        prev_ab = {q.A, q.B};
        mon_en  = 1'b1;
    endtask

    task automatic start_run(input int period, input int burst, input bit rev, output int st);
        @(negedge clk);
        q.EdgePeriod = period;
        q.BurstEdges = burst;
        q.Reverse    = rev;
        q.Start      = 1'b1;
        @(negedge clk);
        q.Start = 1'b0;
        st      = cyc;
        check_val("busy_rise", q.Busy, 1);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 5000; i++) begin
            if (cyc >= target) break;
            @(negedge clk);
        end
        if (cyc < target) check_val("wait_timeout", cyc, target);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (!q.Busy && edge_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("idle_timeout", 0, 1);
    endtask

    task automatic do_stop();
        q.Stop = 1'b1;
        @(negedge clk);
        q.Stop = 1'b0;
        check_val("stop_busy_low", q.Busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        prev_ab  = 2'b00;
        m_idx = 0;
        m_pos = 32'd0;
        m_rev = 0;
        rst_n = 1'b0;
        q.Start = 1'b0; q.Stop = 1'b0; q.Reverse = 1'b0; q.PosClear = 1'b0;
        q.EdgePeriod = '0; q.BurstEdges = '0;
        w.Start = 1'b0; w.Stop = 1'b0; w.Reverse = 1'b0; w.PosClear = 1'b0;
        w.EdgePeriod = '0; w.BurstEdges = '0;
        repeat (3) @(negedge clk);
        check_val("rst_a", q.A, 0);
        check_val("rst_b", q.B, 0);
        check_val("rst_z", q.Z, 0);
        check_val("rst_busy", q.Busy, 0);
        check_val("rst_done", q.Done, 0);
        check_val("rst_pos", q.Position, 0);
        rst_n   = 1'b1;
        prev_ab = 2'b00;
        mon_en  = 1'b1;

        // 8-edge forward burst at period 10
        start_run(10, 8, 1'b0, s);
        for (int k = 1; k <= 8; k++) push_edge(s + 10 * k, 1'b0, 1'b0);
        done_q.push_back(s + 81);
        wait_idle();
        check_val("burst_pos", q.Position, 8);
        check_val("burst_busy", q.Busy, 0);

        // Continuous at period 1 (clamped to 2), stopped after 5 edges
        do_reset();
        start_run(1, 0, 1'b0, s);
        for (int k = 1; k <= 5; k++) push_edge(s + 2 * k, 1'b0, 1'b0);
        wait_cyc(s + 10);
        do_stop();
        repeat (20) @(negedge clk);
        check_val("stop_pos", q.Position, 5);
        check_val("stop_ab_frozen", {q.A, q.B}, ab_of(m_idx));
        check_val("stop_q_empty", edge_q.size(), 0);

        // Direction change after 3 forward edges
        do_reset();
        start_run(4, 0, 1'b0, s);
        for (int k = 1; k <= 3; k++) push_edge(s + 4 * k, 1'b0, 1'b0);
        wait_cyc(s + 12);
        check_val("rev_pos_before", q.Position, 3);
        q.Reverse = 1'b1;
        push_edge(s + 16, 1'b1, 1'b0);
        push_edge(s + 20, 1'b1, 1'b0);
        wait_cyc(s + 16);
        check_val("rev_pos_after", q.Position, 2);
        wait_cyc(s + 20);
        do_stop();
        q.Reverse = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rev_q_empty", edge_q.size(), 0);

        // PosClear coincident with an edge at Position=100
        do_reset();
        start_run(2, 100, 1'b0, s);
        for (int k = 1; k <= 100; k++) push_edge(s + 2 * k, 1'b0, 1'b0);
        done_q.push_back(s + 201);
        wait_idle();
        check_val("pos_100", q.Position, 100);
        start_run(4, 0, 1'b0, s);
        push_edge(s + 4, 1'b0, 1'b1);
        push_edge(s + 8, 1'b0, 1'b0);
        wait_cyc(s + 3);
        q.PosClear = 1'b1;
        @(negedge clk);
        q.PosClear = 1'b0;
        wait_cyc(s + 8);
        do_stop();
        repeat (5) @(negedge clk);
        check_val("clr_pos_after", q.Position, 1);

        // Reset asserted mid-burst, then a full burst
        do_reset();
        start_run(10, 8, 1'b0, s);
        for (int k = 1; k <= 8; k++) push_edge(s + 10 * k, 1'b0, 1'b0);
        done_q.push_back(s + 81);
        wait_cyc(s + 42);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_val("mid_rst_a", q.A, 0);
        check_val("mid_rst_b", q.B, 0);
        check_val("mid_rst_busy", q.Busy, 0);
        check_val("mid_rst_pos", q.Position, 0);
        edge_q.delete();
        done_q.delete();
        m_idx = 0;
        m_pos = 32'd0;
        m_rev = 0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        prev_ab = {q.A, q.B};
        mon_en  = 1'b1;
        start_run(10, 8, 1'b0, s);
        for (int k = 1; k <= 8; k++) push_edge(s + 10 * k, 1'b0, 1'b0);
        done_q.push_back(s + 81);
        wait_idle();
        check_val("rerun_pos", q.Position, 8);

        // 24 forward edges: Z per edge from the model (index builds pulse at 8, 16, 24)
        do_reset();
        start_run(3, 0, 1'b0, s);
        for (int k = 1; k <= 24; k++) push_edge(s + 3 * k, 1'b0, 1'b0);
        wait_cyc(s + 72);
        check_val("idx_z_at_24", q.Z, INDEX_EN);
        do_stop();
        repeat (5) @(negedge clk);
        check_val("idx_q_empty", edge_q.size(), 0);

        // Signed wrap on a 4-bit position: 7 -> -8
        @(negedge clk);
        w.EdgePeriod = 2;
        w.BurstEdges = 8;
        w.Start      = 1'b1;
        @(negedge clk);
        w.Start = 1'b0;
        s       = cyc;
        wait_cyc(s + 14);
        check_val("wrap_pos_max", w.Position, 4'h7);
        wait_cyc(s + 16);
        check_val("wrap_pos_min", w.Position, 4'h8);
        wait_cyc(s + 17);
        check_val("wrap_done", w.Done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/quad_encoder_emulator.md
# quad_encoder_emulator

Generates two-channel quadrature (A/B) wheel-encoder waveforms at a programmable edge rate and direction. It is the transmitting end of the encoder interface that the drive block decodes into distance. It sits in the debug/bench path of the vehicle fabric and is routed to GPIO, so drive and encoder logic can be exercised without a spinning wheel. It supports continuous running or a burst of exactly N edges, and tracks its own signed position for cross-checking the decoder.

## Interface
- EDGE_PERIOD_W, 24: width of the edge-period input.
- BURST_W, 16: width of the burst edge count.
- POS_W, 32: width of the signed position counter.
- EDGES_PER_REV, 80: quadrature edges per emulated wheel revolution. Only used with the index feature.

Ports (name, direction, width, meaning):
- CLOCK_50 in 1: 50 MHz system clock. All logic is on the rising edge.
- Reset in 1: asynchronous, active-low reset.
- Start in 1: one-cycle pulse that begins emission.
- Stop in 1: one-cycle pulse that ends emission.
- Reverse in 1: 0 = forward (A leads B), 1 = reverse (B leads A).
- EdgePeriod in EDGE_PERIOD_W: clocks between successive quadrature edges.
- BurstEdges in BURST_W: edges to emit, sampled at Start. 0 = continuous.
- PosClear in 1: synchronous clear of Position.
- A out 1: encoder channel A.
- B out 1: encoder channel B.
- Z out 1: index pulse.
- Busy out 1: high while emitting.
- Done out 1: one-cycle pulse when a burst completes.
- Position out POS_W: signed edge count. Forward adds 1, reverse subtracts 1.

## Operation
- State machine: IDLE and RUN.
  - IDLE → RUN on Start, unless Stop is asserted in the same cycle. The sampled BurstEdges is loaded into the remaining counter and the timer is loaded with the effective period.
  - RUN → IDLE on Stop. A/B hold their current phase, and Done is not pulsed.
  - RUN → IDLE when the remaining counter reaches 0 after the final edge of a burst. Done pulses once.
  - Start while in RUN is ignored.
- Effective period = max(EdgePeriod, 2). EdgePeriod is sampled live at each timer reload, so a rate change applies from the next edge.
- Timer: a down-counter. When it reaches 1 in RUN, the phase advances by one step on the next clock and the timer reloads.
- Phase sequence as AB:
  - Forward: 00→10→11→01→00.
  - Reverse: the same sequence in the opposite order.
  - Reverse is sampled at each edge. A direction change mid-run steps back from the current phase; it never skips a phase and never moves A and B together.
- Position: ±1 per edge, two's-complement wrap at 2^(POS_W-1).
  - PosClear has priority over a coincident edge: Position = 0 that cycle and the edge is not counted.
- Burst: the remaining counter decrements per edge. Continuous mode (0) never decrements and never asserts Done.

## Timing
- Reset values: A=0, B=0, Z=0, Busy=0, Done=0, Position=0, state IDLE, timer 0, remaining 0, phase 00, revolution counter 0.
- Reset is asynchronous. Assertion mid-run forces all outputs low or zero immediately, with no further edge or Done.
- A, B, Z and Busy are registered outputs, glitch-free.
- Busy rises on the clock after Start is sampled.
- The first edge appears exactly P clocks after the Start cycle, where P is the effective period. Later edges are spaced P clocks apart.
- Done is high for the single cycle after the final A/B edge of a burst. Busy falls in that same cycle.
- Stop takes effect in the cycle it is sampled. No edge is emitted in or after that cycle.

## Configuration
- QENC_INDEX_EN defined:
  - A revolution counter counts edges modulo EDGES_PER_REV, up when forward and down when reverse.
  - Z is high for exactly one quadrature state: the state where AB = 00 and the revolution count = 0.
  - PosClear also zeroes the revolution counter.
- QENC_INDEX_EN undefined: Z is tied to 0 and the revolution counter is not built.

## Test plan
- Reset, then Start with EdgePeriod=10, BurstEdges=8, Reverse=0 → AB steps 10,11,01,00,10,11,01,00 at cycles 10,20,…,80 after Start. Position=8, Done pulses once at cycle 81, then Busy=0.
- Continuous run with EdgePeriod=1 → edges every 2 clocks (clamp). Stop after 5 edges → A/B frozen, Position=5, no Done.
- Reverse toggled after 3 forward edges of a continuous run → next edge returns to the previous phase, Position goes 3→2. No simultaneous A/B change at any point.
- PosClear asserted in the same cycle as an edge with Position=100 → Position=0 and the phase still advances. Separately, Position=0x7FFFFFFF plus one forward edge → 0x80000000.
- Reset asserted mid-burst (edge 4 of 8) → A=B=Busy=Position=0 asynchronously. A new Start runs a full 8-edge burst.
- With QENC_INDEX_EN, EDGES_PER_REV=8, forward continuous for 24 edges → Z high for exactly one edge interval at edges 8, 16 and 24. Without the macro, Z=0 throughout.
